// File: rtl/cpa_aes_launcher.sv
// -----------------------------------------------------------------------------
// cpa_aes_launcher
//
// Sequences one AES encryption per trace for an unattended CPA campaign.
// Each trace latches the source plaintext, key and index, pulses aes_start,
// raises the scope trigger for TRIG_WIDTH clocks, waits for aes_done, and
// captures the ciphertext. Completed traces are counted. A missing completion
// within TIMEOUT clocks of WAIT raises a sticky error and parks the FSM.
//
// Ports
//   clk_text_input  system clock, rising edge
//   reset           asynchronous, active-high
//   arm             level request, rising edge starts one trace
//   auto            1 = chain the next trace right after capture
//   text_in/key_in/text_index   source-stage plaintext, key, index
//   aes_text/aes_key            latched operands to the AES core
//   aes_start                   one-clock launch pulse
//   aes_done/aes_cipher         AES completion strobe and result
//   cipher_out/cipher_index     last captured ciphertext and its index
//   cipher_valid                one-clock pulse on capture
//   scope_trigger               oscilloscope trigger
//   busy                        high in LOAD, START and WAIT
//   trace_count                 completed traces
//   campaign_done               high in FINISH
//   timeout_err                 sticky timeout flag
// -----------------------------------------------------------------------------
module cpa_aes_launcher #(
  parameter int CYPHER_SIZE = 128,
  parameter int NUM_TRACES  = 101,
  parameter int TRIG_WIDTH  = 4,
  parameter int TIMEOUT     = 200
) (
  input  logic                   clk_text_input,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   auto,
  input  logic [127:0]           text_in,
  input  logic [CYPHER_SIZE-1:0] key_in,
  input  logic [7:0]             text_index,
  output logic [127:0]           aes_text,
  output logic [CYPHER_SIZE-1:0] aes_key,
  output logic                   aes_start,
  input  logic                   aes_done,
  input  logic [127:0]           aes_cipher,
  output logic [127:0]           cipher_out,
  output logic [7:0]             cipher_index,
  output logic                   cipher_valid,
  output logic                   scope_trigger,
  output logic                   busy,
  output logic [7:0]             trace_count,
  output logic                   campaign_done,
  output logic                   timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [3:0] TRIG_LOAD   = 4'(TRIG_WIDTH);
  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);
  localparam logic [7:0] NUM_VAL     = 8'(NUM_TRACES);

  state_t      state_reg, state_next;
  logic        arm_q;
  logic [3:0]  trig_cnt_reg;
  logic [7:0]  wait_cnt_reg;
  logic [7:0]  index_reg;

  logic        arm_edge;
  logic [7:0]  wait_inc;
  logic [7:0]  count_inc;
  logic        load_en;
  logic        start_en;
  logic        capture_en;
  logic        timeout_hit;

  assign arm_edge  = arm & ~arm_q;
  assign wait_inc  = wait_cnt_reg + 8'd1;
  assign count_inc = trace_count + 8'd1;

  assign busy          = (state_reg == S_LOAD) || (state_reg == S_START) ||
                         (state_reg == S_WAIT);
  assign campaign_done = (state_reg == S_FINISH);
  // Trigger counter is loaded in START, so the trigger goes high on the same
  // edge that raises aes_start and stays for TRIG_WIDTH clocks.
  assign scope_trigger = (trig_cnt_reg != 4'd0);

  always_ff @(posedge clk_text_input or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    load_en     = 1'b0;
    start_en    = 1'b0;
    capture_en  = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (arm_edge) state_next = S_LOAD;
      end
      S_LOAD: begin
        load_en    = 1'b1;
        state_next = S_START;
      end
      S_START: begin
        start_en   = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // Completion is checked before the timeout so a done arriving on the
        // boundary clock is still captured without raising the error.
        if (aes_done) begin
          capture_en = 1'b1;
          if (count_inc == NUM_VAL) state_next = S_FINISH;
          else if (auto)            state_next = S_LOAD;
          else                      state_next = S_IDLE;
        end else if (wait_inc == TIMEOUT_VAL) begin
          timeout_hit = 1'b1;
          state_next  = S_FINISH;
        end
      end
      S_FINISH: begin
        state_next = S_FINISH;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_text_input or posedge reset) begin
    if (reset) begin
      arm_q        <= 1'b0;
      aes_text     <= '0;
      aes_key      <= '0;
      index_reg    <= 8'd0;
      aes_start    <= 1'b0;
      trig_cnt_reg <= 4'd0;
      wait_cnt_reg <= 8'd0;
      cipher_out   <= '0;
      cipher_index <= 8'd0;
      cipher_valid <= 1'b0;
      trace_count  <= 8'd0;
      timeout_err  <= 1'b0;
    end else begin
      arm_q        <= arm;
      aes_start    <= start_en;
      cipher_valid <= capture_en;

      if (load_en) begin
        aes_text  <= text_in;
        aes_key   <= key_in;
        index_reg <= text_index;
      end

      if (start_en)                 trig_cnt_reg <= TRIG_LOAD;
      else if (trig_cnt_reg != 4'd0) trig_cnt_reg <= trig_cnt_reg - 4'd1;

      if (start_en)                wait_cnt_reg <= 8'd0;
      else if (state_reg == S_WAIT) wait_cnt_reg <= wait_inc;

      if (capture_en) begin
        cipher_out   <= aes_cipher;
        cipher_index <= index_reg;
        trace_count  <= count_inc;
      end

      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

endmodule
